// File: rtl/foc_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined 32x32 multiplier among NREQ requesters.
// Define FOC_MUL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no rotating pointer).
module foc_mul_arbiter #(
  parameter int NREQ    = 3,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [63:0]        mul_result,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [63:0]        rsp_data,
  output logic               busy
);
  // Handshake: a pair transfers when req_valid[i] & req_ready[i]; req_ready never depends
  // on the pair itself, at most one bit is high, and responses carry no backpressure.
  localparam int NST = MUL_LAT + 1;

  logic [7:0]       vld8;
  logic [2:0]       start;
  logic             found;
  logic [2:0]       gid;
  logic             grant;
  logic [3:0]       idx;

  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [NST-1:0]   tv_q, tv_d;
  logic [2:0]       tid_q [NST];
  logic [2:0]       tid_d [NST];
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_data_q, rsp_data_d;

`ifdef FOC_MUL_ARB_FIXED_PRIO_EN
  assign start = 3'd0;
`else
  logic [2:0] ptr_q, ptr_d;

  assign start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (gid == 3'(NREQ - 1)) ? 3'd0 : gid + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 3'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Circular search starting at 'start'; the first pending requester wins.
  always_comb begin
    vld8  = 8'(req_valid);
    found = 1'b0;
    gid   = 3'd0;
    idx   = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, start} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!found && vld8[idx[2:0]]) begin
        found = 1'b1;
        gid   = idx[2:0];
      end
    end
    grant     = found & ~rst;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant && gid == 3'(k)) req_ready[k] = 1'b1;
    end
  end

  // Operands hold when idle so the multiplier inputs do not toggle.
  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    for (int k = 0; k < NREQ; k++) begin
      if (grant && gid == 3'(k)) begin
        mul_a_d = req_a[k*32 +: 32];
        mul_b_d = req_b[k*32 +: 32];
      end
    end
  end

  always_comb begin
    tv_d     = {tv_q[NST-2:0], grant};
    tid_d[0] = gid;
    for (int s = 1; s < NST; s++) tid_d[s] = tid_q[s-1];
  end

  // The last tag stage lines up with mul_result for the same pair.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tv_q[NST-1]) begin
      rsp_data_d = mul_result;
      for (int k = 0; k < NREQ; k++) begin
        if (tid_q[NST-1] == 3'(k)) rsp_valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tv_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int s = 0; s < NST; s++) tid_q[s] <= '0;
    end else begin
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tv_q        <= tv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int s = 0; s < NST; s++) tid_q[s] <= tid_d[s];
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (|tv_q) & ~rst;

endmodule

// File: tb/tb_foc_mul_arbiter.sv
// Self-checking bench for foc_mul_arbiter: scenario tasks plus a queue-based response scoreboard.
// Honors FOC_MUL_ARB_FIXED_PRIO_EN when the build defines it.
module tb_foc_mul_arbiter;
  localparam int NREQ    = 3;
  localparam int MUL_LAT = 3;
  localparam int RLAT    = MUL_LAT + 2;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [63:0]        mul_result;
  logic [NREQ-1:0]    rsp_valid;
  logic [63:0]        rsp_data;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 0;
  int n_acc    = 0;
  int n_pulse  = 0;

  // scoreboard entry: {due_cycle[31:0], id[7:0], product[63:0]}
  logic [103:0] exp_q[$];
  int           m_ptr      = 0;
  logic [31:0]  m_mul_a    = 0;
  logic [31:0]  m_mul_b    = 0;
  logic [63:0]  m_rsp_data = 0;
  logic [63:0]  mpipe [MUL_LAT];

  logic [31:0]  last_a, last_b;

  foc_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural multiplier: MUL_LAT cycles from registered operands to mul_result
  always @(posedge clk) begin
    mpipe[0] <= 64'(mul_a) * 64'(mul_b);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  // scoreboard / reference model
  initial begin
    logic [103:0]    e;
    logic [NREQ-1:0] exp_v;
    logic [NREQ-1:0] exp_rdy;
    logic [63:0]     exp_d;
    int              g;
    int              j;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          checks++;
          if (req_ready !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sb_reset: req_ready=%b busy=%b, required 0/0", req_ready, busy);
          end
          exp_q.delete();
          m_ptr = 0; m_mul_a = 0; m_mul_b = 0; m_rsp_data = 0;
        end else begin
          exp_v = '0;
          exp_d = m_rsp_data;
          if (exp_q.size() > 0 && int'(exp_q[0][103:72]) == cyc) begin
            e     = exp_q.pop_front();
            exp_v = NREQ'(1) << e[71:64];
            exp_d = e[63:0];
            m_rsp_data = exp_d;
          end
          if (rsp_valid !== '0) n_pulse++;
          checks++;
          if (rsp_valid !== exp_v || rsp_data !== exp_d) begin
            failures++;
            $display("FAIL sb_rsp cyc=%0d: rsp_valid=%b rsp_data=%h, required %b %h",
                     cyc, rsp_valid, rsp_data, exp_v, exp_d);
          end
          checks++;
          if (busy !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL sb_busy cyc=%0d: busy=%b, required %b", cyc, busy, exp_q.size() != 0);
          end
          checks++;
          if (mul_a !== m_mul_a || mul_b !== m_mul_b) begin
            failures++;
            $display("FAIL sb_mul_ops cyc=%0d: mul_a=%h mul_b=%h, required %h %h",
                     cyc, mul_a, mul_b, m_mul_a, m_mul_b);
          end
          g = -1;
          for (int k = 0; k < NREQ; k++) begin
`ifdef FOC_MUL_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (m_ptr + k) % NREQ;
`endif
            if (g < 0 && req_valid[j]) g = j;
          end
          exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
          checks++;
          if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL sb_grant cyc=%0d: req_ready=%b, required %b", cyc, req_ready, exp_rdy);
          end
          if (g >= 0) begin
            exp_q.push_back({32'(cyc + RLAT), 8'(g),
                             64'(req_a[g*32 +: 32]) * 64'(req_b[g*32 +: 32])});
            m_mul_a = req_a[g*32 +: 32];
            m_mul_b = req_b[g*32 +: 32];
            m_ptr   = (g + 1) % NREQ;
            n_acc++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rand_ops();
    next_cycle();
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: req_ready=%b busy=%b, required 0/0", req_ready, busy);
    end
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0 || rsp_data !== 64'd0 || mul_a !== 32'd0 || mul_b !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: rsp_valid=%b rsp_data=%h mul_a=%h mul_b=%h busy=%b, required all zero",
               rsp_valid, rsp_data, mul_a, mul_b, busy);
    end
    next_cycle();
  endtask

  task automatic test_single();
    set_req(1, 32'hFFFF_FFF0, 32'h0859_3312);
    req_valid = NREQ'(2);
    @(negedge clk);
    checks++;
    if (req_ready !== NREQ'(2)) begin
      failures++;
      $display("FAIL single_grant: req_ready=%b, required %b", req_ready, NREQ'(2));
    end
    next_cycle();
    req_valid = '0;
    for (int k = 1; k <= RLAT; k++) begin
      @(negedge clk);
      checks++;
      if (k <= MUL_LAT + 1) begin
        if (busy !== 1'b1 || rsp_valid !== '0) begin
          failures++;
          $display("FAIL single_inflight t+%0d: busy=%b rsp_valid=%b, required 1 and 0", k, busy, rsp_valid);
        end
      end else if (rsp_valid !== NREQ'(2) || rsp_data !== 64'h0859_3311_7A6C_CEE0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL single_rsp: rsp_valid=%b rsp_data=%h busy=%b, required 010 0859_3311_7A6C_CEE0 0",
                 rsp_valid, rsp_data, busy);
      end
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    logic [NREQ-1:0] exp_rdy;
    rst = 1'b1;
    req_valid = '1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3 * NREQ; k++) begin
      rand_ops();
      @(negedge clk);
`ifdef FOC_MUL_ARB_FIXED_PRIO_EN
      exp_rdy = NREQ'(1);
`else
      exp_rdy = NREQ'(1) << (k % NREQ);
`endif
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL saturation_grant k=%0d: req_ready=%b, required %b", k, req_ready, exp_rdy);
      end
      next_cycle();
    end
    idle(RLAT + 2);
  endtask

  task automatic test_rr_wrap();
    logic [NREQ-1:0] exp_rdy;
    rand_ops();
    req_valid = NREQ'(1) << (NREQ - 1);
    @(negedge clk);
    checks++;
    if (req_ready !== (NREQ'(1) << (NREQ - 1))) begin
      failures++;
      $display("FAIL rr_wrap_last: req_ready=%b, required %b", req_ready, NREQ'(1) << (NREQ - 1));
    end
    next_cycle();
    req_valid = (NREQ'(1) << (NREQ - 1)) | NREQ'(1);
    for (int k = 0; k < 2; k++) begin
      rand_ops();
      @(negedge clk);
`ifdef FOC_MUL_ARB_FIXED_PRIO_EN
      exp_rdy = NREQ'(1);
`else
      exp_rdy = (k == 0) ? NREQ'(1) : (NREQ'(1) << (NREQ - 1));
`endif
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rr_wrap k=%0d: req_ready=%b, required %b", k, req_ready, exp_rdy);
      end
      next_cycle();
    end
    idle(RLAT + 2);
  endtask

  task automatic test_prio_pair();
    logic [NREQ-1:0] exp_rdy;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    req_valid = NREQ'(1) | (NREQ'(1) << 2);
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      @(negedge clk);
`ifdef FOC_MUL_ARB_FIXED_PRIO_EN
      exp_rdy = NREQ'(1);
`else
      exp_rdy = (k % 2 == 0) ? NREQ'(1) : (NREQ'(1) << 2);
`endif
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL prio_pair k=%0d: req_ready=%b, required %b", k, req_ready, exp_rdy);
      end
      next_cycle();
    end
    idle(RLAT + 2);
  endtask

  task automatic test_reset_midflight();
    logic [63:0] prod;
    for (int i = 0; i < NREQ; i++) begin
      rand_ops();
      req_valid = NREQ'(1) << i;
      @(negedge clk);
      checks++;
      if (req_ready !== (NREQ'(1) << i)) begin
        failures++;
        $display("FAIL midflight_accept %0d: req_ready=%b, required %b", i, req_ready, NREQ'(1) << i);
      end
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midflight_in_reset: req_ready=%b busy=%b, required 0/0", req_ready, busy);
    end
    next_cycle();
    rst = 1'b0;
    last_a = $urandom;
    last_b = $urandom;
    set_req(1, last_a, last_b);
    prod = 64'(last_a) * 64'(last_b);
    req_valid = NREQ'(2);
    @(negedge clk);
    checks++;
    if (req_ready !== NREQ'(2) || rsp_valid !== '0) begin
      failures++;
      $display("FAIL midflight_first_accept: req_ready=%b rsp_valid=%b, required 010 000", req_ready, rsp_valid);
    end
    next_cycle();
    req_valid = '0;
    for (int k = 1; k <= RLAT; k++) begin
      @(negedge clk);
      checks++;
      if (k < RLAT) begin
        if (rsp_valid !== '0) begin
          failures++;
          $display("FAIL midflight_dropped t+%0d: rsp_valid=%b, required 0", k, rsp_valid);
        end
      end else if (rsp_valid !== NREQ'(2) || rsp_data !== prod) begin
        failures++;
        $display("FAIL midflight_rsp: rsp_valid=%b rsp_data=%h, required 010 %h", rsp_valid, rsp_data, prod);
      end
    end
    next_cycle();
  endtask

  task automatic test_idle();
    logic [NREQ-1:0] exp_rdy;
    req_valid = '0;
    for (int k = 0; k < 20; k++) begin
      rand_ops();
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || mul_a !== last_a || mul_b !== last_b) begin
        failures++;
        $display("FAIL idle k=%0d: rsp_valid=%b mul_a=%h mul_b=%h, required 0 %h %h",
                 k, rsp_valid, mul_a, mul_b, last_a, last_b);
      end
      next_cycle();
    end
    req_valid = '1;
    @(negedge clk);
`ifdef FOC_MUL_ARB_FIXED_PRIO_EN
    exp_rdy = NREQ'(1);
`else
    exp_rdy = NREQ'(1) << 2;
`endif
    checks++;
    if (req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL idle_ptr_kept: req_ready=%b, required %b", req_ready, exp_rdy);
    end
    next_cycle();
    idle(RLAT + 2);
  endtask

  task automatic test_random();
    int acc0;
    int pul0;
    acc0 = n_acc;
    pul0 = n_pulse;
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      next_cycle();
    end
    idle(RLAT + 3);
    checks++;
    if (exp_q.size() != 0 || (n_pulse - pul0) != (n_acc - acc0)) begin
      failures++;
      $display("FAIL random_drain: pending=%0d responses=%0d, required 0 and %0d",
               exp_q.size(), n_pulse - pul0, n_acc - acc0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    last_a = '0;
    last_b = '0;
    test_reset();
    test_single();
    test_saturation();
    test_rr_wrap();
    test_prio_pair();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
